// File: rtl/corefifo_wr_ptr_full_gen_if.sv
// Write-side bus of the dual-clock FIFO: producer request, RAM write port,
// Gray pointer exchange with the read domain and write-side status flags.
interface corefifo_wr_ptr_full_gen_if #(
    parameter int unsigned ADDRWIDTH = 3
);
    logic                 we;
    logic                 wr_en_mem;
    logic [ADDRWIDTH-1:0] waddr;
    logic [ADDRWIDTH:0]   wptr_gray;
    logic [ADDRWIDTH:0]   rptr_gray_sync;
    logic                 full;
    logic                 afull;
    logic [ADDRWIDTH:0]   wrcnt;
    logic                 overflow;

    modport master (
        output we,
        output rptr_gray_sync,
        input  wr_en_mem,
        input  waddr,
        input  wptr_gray,
        input  full,
        input  afull,
        input  wrcnt,
        input  overflow
    );

    modport slave (
        input  we,
        input  rptr_gray_sync,
        output wr_en_mem,
        output waddr,
        output wptr_gray,
        output full,
        output afull,
        output wrcnt,
        output overflow
    );
endinterface

// File: rtl/corefifo_wr_ptr_full_gen.sv
// Write-clock-domain pointer and flag generator for the dual-clock FIFO:
// gates writes on full, advances the pointer, publishes it in Gray code.
module corefifo_wr_ptr_full_gen #(
    parameter int unsigned ADDRWIDTH    = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                             clk,
    input  logic                             arstn,
    corefifo_wr_ptr_full_gen_if.slave        bus
);
    localparam int unsigned PW = ADDRWIDTH + 1;
    localparam logic [PW-1:0] THRESH = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] fill_next;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] wrcnt_q;
    logic          full_q;
    logic          afull_q;
    logic          overflow_q;
    logic          accept;

    assign accept    = bus.we & ~full_q;
    assign wbin_next = wbin + PW'(accept);
    assign fill_next = wbin_next - rbin;

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            rbin[i] = ^(bus.rptr_gray_sync >> i);
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            wbin       <= '0;
            gray_q     <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            wrcnt_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wbin       <= wbin_next;
            gray_q     <= wbin_next ^ (wbin_next >> 1);
            full_q     <= (wbin_next[PW-1] != rbin[PW-1]) &&
                          (wbin_next[PW-2:0] == rbin[PW-2:0]);
            afull_q    <= fill_next >= THRESH;
            wrcnt_q    <= fill_next;
            overflow_q <= bus.we & full_q;
        end
    end

    assign bus.wr_en_mem = accept;
    assign bus.waddr     = wbin[PW-2:0];
    assign bus.wptr_gray = gray_q;
    assign bus.full      = full_q;
    assign bus.afull     = afull_q;
    assign bus.wrcnt     = wrcnt_q;
    assign bus.overflow  = overflow_q;
endmodule
